// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;
    localparam int SA_DEFAULT_WIDTH = 8;
endpackage

// File: rtl/full_adder.sv
// Combinational full-adder cell built from two half adders and an OR gate.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic w_s1;
    logic w_c1;
    logic w_c2;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (w_s1),
        .carry (w_c1)
    );

    half_adder u_ha1 (
        .a     (w_s1),
        .b     (cin),
        .sum   (sum),
        .carry (w_c2)
    );

    assign cout = w_c1 | w_c2;
endmodule

// File: rtl/half_adder.sv
// Single-bit half adder: sum is the XOR, carry is the AND of the two inputs.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell processes LSB-first, one bit per clock.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH);

    sa_state_t        r_state;
    sa_state_t        w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic             w_fa_s;
    logic             w_fa_c;
    logic             w_last;

    assign w_last = (r_count == CW'(WIDTH - 1));

    full_adder u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_fa_s),
        .cout (w_fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
    end

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_sum   <= '0;
                        r_carry <= 1'b0;
                        r_count <= '0;
                    end
                end
                SHIFT: begin
                    r_sum   <= {w_fa_s, r_sum[WIDTH-1:1]};
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_carry <= w_fa_c;
                    if (!w_last) begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum_out   = r_sum;
    assign carry_out = r_carry;
endmodule
